sbox_word_arbiter: RTL
======================

// Module: sbox_word_arbiter
// PURPOSE
//   Shares one byte-wide registered S-box between two 32-bit word requesters:
//   port 0 = key expansion (SubWord), port 1 = round datapath (SubBytes column).
//   Grants whole words round-robin, issues the 4 byte lookups in order, and
//   reassembles the result in the original byte positions, with no rotation.
//   Sits between the requesters and the S-box instance and replaces per-user sel FSMs.
// PARAMETERS
//   SBOX_LAT  1  cycles from sbox_addr/sbox_valid sampled to sbox_dout valid (1..3)
// PORTS
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low reset (0 = reset)
//   req0_valid   in   1   port 0 has a word to substitute
//   req0_word    in   32  port 0 input word
//   req0_ready   out  1   port 0 word accepted on clk edge when valid&ready
//   req0_done    out  1   one-cycle pulse: req0_result is valid
//   req0_result  out  32  port 0 substituted word, held until next port-0 done
//   req1_*       -    -   identical set for port 1
//   sbox_addr    out  8   byte presented to S-box
//   sbox_valid   out  1   S-box lookup enable
//   sbox_dout    in   8   S-box output, SBOX_LAT cycles after its address
//   busy         out  1   1 in any state other than IDLE
//   grant_id     out  1   port currently owning the S-box (0/1)
// BEHAVIOUR
//   Reset (async, reset=0): state IDLE; every output 0 (readys, dones, results,
//     sbox_addr, sbox_valid, busy, grant_id); last_grant=1 so port 0 wins first.
//   States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE: reqX_ready = 1 only for the port the arbiter selects this cycle:
//     exactly one valid port -> that port; both valid -> port != last_grant.
//     On valid&ready: latch word, set grant_id and last_grant, idx=0, go ISSUE.
//     A requester that drops valid before acceptance has no effect.
//   ISSUE (4 cycles): sbox_valid=1, sbox_addr = latched byte idx
//     (idx0=[31:24], idx1=[23:16], idx2=[15:8], idx3=[7:0]); idx++.
//     After idx3 go DRAIN. Later changes on reqX_word are ignored.
//   Capture: sbox_valid and idx pass through a SBOX_LAT-deep tag pipe. When a
//     tag emerges, sbox_dout is written to the result byte at that tag's idx.
//   DRAIN: sbox_valid=0, sbox_addr=0; wait until tag pipe empty, then go DONE.
//   DONE (1 cycle): reqX_done=1 for grant_id port only; reqX_result updated
//     on entry to DONE and stable from then on; other port's result untouched.
//   Timing, accept at edge 0: bytes issued in cycles 1..4, done in cycle 5+SBOX_LAT,
//     IDLE (ready possible) in cycle 6+SBOX_LAT. One word per 6+SBOX_LAT cycles.
//   No readys outside IDLE; a valid held through busy is served on return to IDLE.
//   Fairness: with both ports continuously valid, grants strictly alternate.
//   Reset mid-operation: transaction dropped, no done pulse, results cleared.
//   busy=1 in ISSUE, DRAIN and DONE.
// TESTING
//   1 Port 0 only, word 0x00010253, SBOX_LAT=1 -> done at cycle 6,
//     req0_result=0x637C77ED, sbox_addr sequence 00,01,02,53.
//   2 Port 1 only, word 0xCF4F3C09 -> req1_result=0x8A84EB01;
//     req0_done stays 0 and req0_result is unchanged.
//   3 Both valid at the same edge after reset, held high -> grants alternate
//     0,1,0,1; each result is correct for its own word.
//   4 Change req0_word to 0xFFFFFFFF in cycle 2 after accept of 0x00000000
//     -> result 0x63636363 (latched word used), not 0x16161616.
//   5 reset=0 in cycle 3 of ISSUE -> all outputs 0 immediately, no done.
//     Next request after reset completes correctly.
//   6 Repeat test 1 with SBOX_LAT=2 and 3 -> done at cycles 7 and 8,
//     same result values.

Source files
------------

// File: rtl/sbox_word_arbiter.sv
// Round-robin arbiter that shares one byte-wide registered S-box between two
// 32-bit word requesters, issuing bytes MSB first and reassembling in place.
module sbox_word_arbiter #(
   parameter int SBOX_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [31:0] req0_word,
   output logic        req0_ready,
   output logic        req0_done,
   output logic [31:0] req0_result,
   input  logic        req1_valid,
   input  logic [31:0] req1_word,
   output logic        req1_ready,
   output logic        req1_done,
   output logic [31:0] req1_result,
   output logic [7:0]  sbox_addr,
   output logic        sbox_valid,
   input  logic [7:0]  sbox_dout,
   output logic        busy,
   output logic        grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic                last_grant;
   logic [31:0]         word_q;
   logic [1:0]          idx;
   logic [31:0]         work, work_nxt;
   logic [SBOX_LAT-1:0] tag_valid;
   logic [1:0]          tag_idx [SBOX_LAT];
   logic                sel_port, offer, pipe_quiet;

   // With both ports asking, the one that did not win last time goes next.
   always_comb begin
      sel_port = req1_valid;
      if (req0_valid && req1_valid) sel_port = ~last_grant;
      offer = reset && (state == IDLE) && (req0_valid || req1_valid);
   end

   assign req0_ready = offer && !sel_port;
   assign req1_ready = offer && sel_port;

   // The byte emerging this cycle is captured on the same edge that enters
   // DONE, so only the younger tags have to be empty to leave DRAIN.
   generate
      if (SBOX_LAT == 1) begin : g_quiet_single
         assign pipe_quiet = 1'b1;
      end else begin : g_quiet_multi
         assign pipe_quiet = ~|tag_valid[SBOX_LAT-2:0];
      end
   endgenerate

   always_comb begin
      work_nxt = work;
      if (tag_valid[SBOX_LAT-1]) begin
         case (tag_idx[SBOX_LAT-1])
            2'd0:    work_nxt[31:24] = sbox_dout;
            2'd1:    work_nxt[23:16] = sbox_dout;
            2'd2:    work_nxt[15:8]  = sbox_dout;
            default: work_nxt[7:0]   = sbox_dout;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      sbox_valid = 1'b0;
      sbox_addr  = 8'h00;
      case (state)
         IDLE: begin
            if (offer) state_nxt = ISSUE;
         end
         ISSUE: begin
            sbox_valid = 1'b1;
            case (idx)
               2'd0:    sbox_addr = word_q[31:24];
               2'd1:    sbox_addr = word_q[23:16];
               2'd2:    sbox_addr = word_q[15:8];
               default: sbox_addr = word_q[7:0];
            endcase
            if (idx == 2'd3) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pipe_quiet) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign req0_done = (state == DONE) && !grant_id;
   assign req1_done = (state == DONE) && grant_id;

   // Each issued lookup carries its byte index alongside the S-box latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_valid <= '0;
         for (int i = 0; i < SBOX_LAT; i++) tag_idx[i] <= 2'd0;
      end else begin
         tag_valid[0] <= sbox_valid;
         tag_idx[0]   <= idx;
         for (int i = 1; i < SBOX_LAT; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_idx[i]   <= tag_idx[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         grant_id    <= 1'b0;
         word_q      <= 32'h0;
         idx         <= 2'd0;
         work        <= 32'h0;
         req0_result <= 32'h0;
         req1_result <= 32'h0;
      end else begin
         state <= state_nxt;
         work  <= work_nxt;
         case (state)
            IDLE: begin
               if (offer) begin
                  word_q     <= sel_port ? req1_word : req0_word;
                  grant_id   <= sel_port;
                  last_grant <= sel_port;
                  idx        <= 2'd0;
               end
            end
            ISSUE: begin
               idx <= idx + 2'd1;
            end
            DRAIN: begin
               if (pipe_quiet) begin
                  if (grant_id) req1_result <= work_nxt;
                  else          req0_result <= work_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
